// File: rtl/note_judge.sv
// rtl/note_judge.sv - judges player key presses against the song-engine note stream
//
// Purpose: consumes the engine's curr_note/hold_length stream once per game frame,
// compares it with the synchronized player keys, and grades each note as hit,
// partial or miss. Keeps score, streak and best streak for the display and sound logic.
//
// Ports:
//   game_clock    frame clock shared with the engine
//   game_reset_n  asynchronous active-low reset
//   game_frame    current frame number; frame 0 abandons the note in progress
//   curr_note     one-hot target note, 0 = rest
//   hold_length   frames the current note lasts and must be held
//   keys          raw player key levels, asynchronous to game_clock
//   score         saturating accumulated score
//   streak        consecutive full hits, saturating
//   best_streak   highest streak since reset
//   hit           one-frame pulse on a full hit
//   miss          one-frame pulse on miss, wrong key or early release
//   judge_state   FSM state (IDLE=0, WAIT=1, HOLD=2, DONE=3)

module note_judge #(
  parameter int PRESS_WINDOW = 2,
  parameter int HIT_POINTS   = 10,
  parameter int SCORE_W      = 16
) (
  input  logic               game_clock,
  input  logic               game_reset_n,
  input  logic [7:0]         game_frame,
  input  logic [11:0]        curr_note,
  input  logic [3:0]         hold_length,
  input  logic [11:0]        keys,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         streak,
  output logic [7:0]         best_streak,
  output logic               hit,
  output logic               miss,
  output logic [1:0]         judge_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0]         PW      = 4'(PRESS_WINDOW);
  localparam logic [SCORE_W-1:0] HIT_PTS = SCORE_W'(HIT_POINTS);

  state_t             state_q, state_d;
  logic               rest_q, rest_d;
  logic [11:0]        key_meta, skeys;
  logic [11:0]        tgt_q, tgt_d;
  logic [3:0]         len_q, len_d, len_eff;
  logic [3:0]         age_q, age_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [4:0]         cnt_inc;
  logic [SCORE_W-1:0] add_pts;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_d;
  logic [7:0]         streak_d, best_d;
  logic               hit_d, miss_d;
  logic               frame_zero, boundary, key_match, key_stray;

  assign len_eff    = (len_q == 4'd0) ? 4'd1 : len_q;
  assign frame_zero = (game_frame == 8'd0);
  // The age term splits back-to-back repeats of an identical note.
  assign boundary   = (curr_note != tgt_q) || (hold_length != len_q) ||
                      (age_q == len_eff - 4'd1) || frame_zero;
  assign key_match  = (skeys == tgt_q);
  assign key_stray  = |(skeys & ~tgt_q);
  assign cnt_inc    = {1'b0, cnt_q} + 5'd1;

  assign judge_state = state_q;

  always_comb begin
    state_d   = state_q;
    rest_d    = rest_q;
    tgt_d     = tgt_q;
    len_d     = len_q;
    age_d     = (age_q == 4'hf) ? age_q : age_q + 4'd1;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    add_pts   = '0;
    score_sum = '0;
    score_d   = score;
    streak_d  = streak;
    best_d    = best_streak;

    // Judge this frame of the current note. The boundary frame is also the
    // note's last frame, so it is judged here before the new note is latched.
    unique case (state_q)
      WAIT: begin
        if (key_match) begin
          cnt_d = 4'd1;
          if (len_eff == 4'd1) begin
            hit_d   = 1'b1;
            add_pts = HIT_PTS;
            state_d = DONE;
          end else begin
            state_d = HOLD;
          end
        end else if (key_stray || (age_q >= PW)) begin
          miss_d  = 1'b1;
          state_d = DONE;
        end
      end
      HOLD: begin
        if (key_match) begin
          cnt_d = cnt_inc[3:0];
          if (cnt_inc >= {1'b0, len_eff}) begin
            hit_d   = 1'b1;
            add_pts = HIT_PTS;
            state_d = DONE;
          end
        end else begin
          miss_d  = 1'b1;
          add_pts = SCORE_W'(cnt_q);
          state_d = DONE;
        end
      end
      DONE: begin
        // Rest notes live in DONE with the rest flag; one miss per dirty rest.
        if (rest_q && (|skeys)) begin
          miss_d = 1'b1;
          rest_d = 1'b0;
        end
      end
      default: begin
      end
    endcase

    if (boundary) begin
      if (frame_zero) begin
        // Frame 0 drops the note in progress without grading it.
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        add_pts = '0;
      end else if (state_d == WAIT) begin
        miss_d = 1'b1;
      end else if (state_d == HOLD) begin
        miss_d  = 1'b1;
        add_pts = SCORE_W'(cnt_d);
      end
      tgt_d   = curr_note;
      len_d   = hold_length;
      age_d   = 4'd0;
      cnt_d   = 4'd0;
      state_d = (curr_note != 12'd0) ? WAIT : DONE;
      rest_d  = (curr_note == 12'd0);
    end

    score_sum = {1'b0, score} + {1'b0, add_pts};
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    if (hit_d) begin
      streak_d = (streak == 8'hff) ? streak : streak + 8'd1;
    end else if (miss_d) begin
      streak_d = 8'd0;
    end
    best_d = (streak_d > best_streak) ? streak_d : best_streak;
  end

  always_ff @(posedge game_clock or negedge game_reset_n) begin
    if (!game_reset_n) begin
      key_meta    <= '0;
      skeys       <= '0;
      state_q     <= IDLE;
      rest_q      <= 1'b0;
      tgt_q       <= '0;
      len_q       <= '0;
      age_q       <= '0;
      cnt_q       <= '0;
      score       <= '0;
      streak      <= '0;
      best_streak <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
    end else begin
      key_meta    <= keys;
      skeys       <= key_meta;
      state_q     <= state_d;
      rest_q      <= rest_d;
      tgt_q       <= tgt_d;
      len_q       <= len_d;
      age_q       <= age_d;
      cnt_q       <= cnt_d;
      score       <= score_d;
      streak      <= streak_d;
      best_streak <= best_d;
      hit         <= hit_d;
      miss        <= miss_d;
    end
  end

endmodule

// File: tb/tb_note_judge.sv
// tb/tb_note_judge.sv - self-checking bench for note_judge

module tb_note_judge;

  logic        game_clock;
  logic        game_reset_n;
  logic [7:0]  game_frame;
  logic [11:0] curr_note;
  logic [3:0]  hold_length;
  logic [11:0] keys;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [7:0]  best_streak;
  logic        hit;
  logic        miss;
  logic [1:0]  judge_state;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic        hit;
    logic        miss;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [7:0]  best;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] m_score;
  logic [7:0]  m_streak;
  logic [7:0]  m_best;

  note_judge #(
    .PRESS_WINDOW(2),
    .HIT_POINTS  (10),
    .SCORE_W     (16)
  ) dut (
    .game_clock  (game_clock),
    .game_reset_n(game_reset_n),
    .game_frame  (game_frame),
    .curr_note   (curr_note),
    .hold_length (hold_length),
    .keys        (keys),
    .score       (score),
    .streak      (streak),
    .best_streak (best_streak),
    .hit         (hit),
    .miss        (miss),
    .judge_state (judge_state)
  );

  initial game_clock = 1'b0;
  always #5 game_clock = ~game_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge game_clock);
      #1;
    end
  endtask

  task automatic set_note(input logic [11:0] n, input logic [3:0] l);
    curr_note   = n;
    hold_length = l;
  endtask

  task automatic model_reset();
    m_score  = 16'd0;
    m_streak = 8'd0;
    m_best   = 8'd0;
  endtask

  task automatic push_hit();
    exp_t e;
    m_score  = (m_score > 16'hffff - 16'd10) ? 16'hffff : m_score + 16'd10;
    m_streak = (m_streak == 8'hff) ? 8'hff : m_streak + 8'd1;
    m_best   = (m_streak > m_best) ? m_streak : m_best;
    e = '{hit: 1'b1, miss: 1'b0, score: m_score, streak: m_streak, best: m_best};
    sb.push_back(e);
  endtask

  task automatic push_miss(input logic [15:0] pts);
    exp_t e;
    m_score  = ({1'b0, m_score} + {1'b0, pts} > 17'h0ffff) ? 16'hffff : m_score + pts;
    m_streak = 8'd0;
    e = '{hit: 1'b0, miss: 1'b1, score: m_score, streak: m_streak, best: m_best};
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_streak"}, 32'(streak), 32'd0);
    check({tag, "_best"}, 32'(best_streak), 32'd0);
    check({tag, "_hit"}, 32'(hit), 32'd0);
    check({tag, "_miss"}, 32'(miss), 32'd0);
    check({tag, "_state"}, 32'(judge_state), 32'd0);
  endtask

  // Scoreboard side: every pulse must match the oldest expected event.
  initial begin
    forever begin
      @(posedge game_clock);
      #1;
      if (game_reset_n && (hit || miss)) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_hit", 32'(hit), 32'(mon_e.hit));
          check("sb_miss", 32'(miss), 32'(mon_e.miss));
          check("sb_score", 32'(score), 32'(mon_e.score));
          check("sb_streak", 32'(streak), 32'(mon_e.streak));
          check("sb_best", 32'(best_streak), 32'(mon_e.best));
        end
      end
    end
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    model_reset();
    game_reset_n = 1'b0;
    game_frame   = 8'd1;
    curr_note    = 12'd0;
    hold_length  = 4'd0;
    keys         = 12'd0;

    #12;
    check_zero("reset");
    game_reset_n = 1'b1;
    tick(2);
    check("rest_after_reset", 32'(judge_state), 32'd3);

    // Full hit, len 3, key down one frame before the note.
    keys = 12'h004;
    tick(1);
    set_note(12'h004, 4'd3);
    tick(1);
    check("a_wait", 32'(judge_state), 32'd1);
    tick(1);
    check("a_hold", 32'(judge_state), 32'd2);
    keys = 12'h000;
    tick(1);
    set_note(12'h000, 4'd0);
    push_hit();
    tick(1);
    check("a_hit", 32'(hit), 32'd1);
    check("a_score", 32'(score), 32'd10);
    check("a_streak", 32'(streak), 32'd1);
    check("a_best", 32'(best_streak), 32'd1);
    tick(1);
    check("a_hit_one_frame", 32'(hit), 32'd0);

    // Early release after two held frames: partial credit.
    keys = 12'h004;
    tick(1);
    set_note(12'h004, 4'd3);
    tick(1);
    keys = 12'h000;
    tick(2);
    check("b_hold", 32'(judge_state), 32'd2);
    set_note(12'h000, 4'd0);
    push_miss(16'd2);
    tick(1);
    check("b_miss", 32'(miss), 32'd1);
    check("b_score", 32'(score), 32'd12);
    check("b_streak", 32'(streak), 32'd0);
    check("b_state", 32'(judge_state), 32'd3);

    // Stray key alongside the target.
    set_note(12'h100, 4'd3);
    keys = 12'h101;
    tick(1);
    keys = 12'h000;
    tick(1);
    check("c_wait", 32'(judge_state), 32'd1);
    push_miss(16'd0);
    tick(1);
    check("c_miss", 32'(miss), 32'd1);
    check("c_state", 32'(judge_state), 32'd3);
    check("c_score", 32'(score), 32'd12);
    set_note(12'h000, 4'd0);
    tick(2);

    // No press on a len-2 note: missed when the note ends.
    set_note(12'h010, 4'd2);
    tick(2);
    check("d_wait", 32'(judge_state), 32'd1);
    set_note(12'h000, 4'd0);
    push_miss(16'd0);
    tick(1);
    check("d_miss", 32'(miss), 32'd1);
    check("d_state", 32'(judge_state), 32'd3);

    // No press on a longer note: missed when the press window expires.
    set_note(12'h010, 4'd5);
    tick(3);
    check("w_wait", 32'(judge_state), 32'd1);
    push_miss(16'd0);
    tick(1);
    check("w_miss", 32'(miss), 32'd1);
    check("w_state", 32'(judge_state), 32'd3);
    tick(1);
    check("w_done_quiet", 32'(miss), 32'd0);
    set_note(12'h000, 4'd0);
    tick(1);

    // Three back-to-back identical len-2 notes, key held throughout.
    keys = 12'h001;
    tick(1);
    set_note(12'h001, 4'd2);
    tick(2);
    push_hit();
    tick(1);
    check("e_hit1", 32'(hit), 32'd1);
    check("e_score1", 32'(score), 32'd22);
    tick(1);
    check("e_gap", 32'(hit), 32'd0);
    check("e_gap_state", 32'(judge_state), 32'd2);
    push_hit();
    tick(1);
    check("e_hit2", 32'(hit), 32'd1);
    check("e_score2", 32'(score), 32'd32);
    keys = 12'h000;
    tick(1);
    set_note(12'h000, 4'd0);
    push_hit();
    tick(1);
    check("e_hit3", 32'(hit), 32'd1);
    tick(2);
    check("rest_streak", 32'(streak), 32'd3);
    check("rest_best", 32'(best_streak), 32'd3);
    check("rest_score", 32'(score), 32'd42);
    check("rest_state", 32'(judge_state), 32'd3);

    // Frame 0 during HOLD abandons the note and restarts it silently.
    keys = 12'h020;
    tick(1);
    set_note(12'h020, 4'd4);
    tick(2);
    check("f_hold", 32'(judge_state), 32'd2);
    game_frame = 8'd0;
    tick(1);
    check("f_restart", 32'(judge_state), 32'd1);
    check("f_no_miss", 32'(miss), 32'd0);
    check("f_score", 32'(score), 32'd42);
    game_frame = 8'd1;
    tick(1);
    check("f_hold_again", 32'(judge_state), 32'd2);
    tick(1);
    keys = 12'h000;
    tick(1);
    set_note(12'h000, 4'd0);
    push_hit();
    tick(1);
    check("f_hit", 32'(hit), 32'd1);
    check("f_streak", 32'(streak), 32'd4);

    // Reset clears everything, then climb to 0xFFFA with len-1 notes.
    #2;
    game_reset_n = 1'b0;
    #1;
    check_zero("reset2");
    model_reset();
    #3;
    game_reset_n = 1'b1;
    tick(1);
    keys = 12'h001;
    tick(1);
    set_note(12'h001, 4'd1);
    tick(1);
    for (int i = 0; i < 6553; i++) begin
      push_hit();
      tick(1);
    end
    check("g_score", 32'(score), 32'hfffa);
    check("g_streak_sat", 32'(streak), 32'hff);
    check("g_best_sat", 32'(best_streak), 32'hff);

    // Reset mid-note: immediate zeros, no pulse.
    #2;
    game_reset_n = 1'b0;
    #1;
    check_zero("reset_mid");
    model_reset();
    keys = 12'h000;
    set_note(12'h000, 4'd0);
    #2;
    game_reset_n = 1'b1;
    tick(1);

    // Climb past the top: score saturates.
    keys = 12'h001;
    tick(1);
    set_note(12'h001, 4'd1);
    tick(1);
    for (int i = 0; i < 6554; i++) begin
      if (i == 6552) keys = 12'h000;
      if (i == 6553) set_note(12'h000, 4'd0);
      push_hit();
      tick(1);
    end
    check("sat_score", 32'(score), 32'hffff);
    check("sat_streak", 32'(streak), 32'hff);
    tick(3);
    check("sat_hold", 32'(score), 32'hffff);
    check("sat_quiet", 32'({hit, miss}), 32'd0);
    check("sat_state", 32'(judge_state), 32'd3);

    tick(2);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Consumer end of the song-engine note stream.
- Watches `curr_note` / `hold_length` from the engine and the player's 12 key inputs, one evaluation per `game_clock` tick (one tick = one game frame).
- Judges each note as hit, partial or miss, and maintains score and streak counters for the display and sound logic.

Parameters:
- PRESS_WINDOW, 2, frames after note start in which the correct key(s) must first be pressed.
- HIT_POINTS, 10, points added for a fully held note.
- SCORE_W, 16, width of score counter.

Ports:
- game_clock  input  1  frame clock shared with the engine.
- game_reset_n  input  1  asynchronous active-low reset.
- game_frame  input  8  current frame number from the game controller.
- curr_note  input  12  one-hot target note from the engine; 0 = rest.
- hold_length  input  4  frames the current note must be held.
- keys  input  12  raw player key levels, bit i = note i; asynchronous to game_clock.
- score  output  SCORE_W  accumulated score.
- streak  output  8  consecutive full hits.
- best_streak  output  8  maximum streak since reset.
- hit  output  1  one-cycle pulse on full hit.
- miss  output  1  one-cycle pulse on miss, wrong key or early release.
- judge_state  output  2  current FSM state encoding.

Behaviour:
- Reset (async, game_reset_n=0): all outputs 0; FSM = IDLE; key synchronizer, latched target and counters cleared.
- Keys pass a 2-flop synchronizer on game_clock. `skeys` = synchronized keys; 2-frame latency, which PRESS_WINDOW absorbs.
- `len_eff` = latched hold length, with 0 treated as 1.
- Note boundary occurs on any of:
  - curr_note or hold_length differs from the latched copy;
  - note_age == len_eff − 1 (same note repeated back-to-back);
  - game_frame == 0.
- On a boundary:
  - latch target = curr_note, len = hold_length;
  - note_age = 0, hold_cnt = 0;
  - FSM → WAIT (target ≠ 0) or REST (target = 0).
- The boundary check has priority over every FSM transition in the same cycle.
- An unfinished note at a boundary is resolved first:
  - WAIT → miss;
  - HOLD → partial;
  - then the new note starts.
- note_age increments every cycle and saturates at 15.
- FSM states: IDLE=0, WAIT=1, HOLD=2, DONE=3. REST is encoded as DONE with a rest flag.
- IDLE: leaves only on a boundary.
- WAIT:
  - skeys == target exactly → HOLD, hold_cnt = 1.
  - skeys has any bit outside target → miss, DONE.
  - note_age ≥ PRESS_WINDOW with no match → miss, DONE.
- HOLD:
  - skeys == target: hold_cnt++.
  - hold_cnt reaching len_eff → hit, score += HIT_POINTS, streak++, DONE.
  - Release or wrong key → partial: score += hold_cnt, streak = 0, miss pulse, DONE.
- REST: any skeys bit set → miss, streak = 0. Clean rest: no score change and streak unaffected.
- DONE: keys ignored until the next boundary.
- Arithmetic:
  - score saturates at 2^SCORE_W − 1; streak and best_streak saturate at 255.
  - best_streak updates in the same cycle streak exceeds it.
- Any miss (including partial) clears streak.
- hit and miss are registered, mutually exclusive and high for exactly one cycle.
- game_frame == 0 mid-note: the current note is abandoned, with no hit/miss/score change for it. Score and streak are not cleared; only reset clears them.
- Reset mid-note: immediate return to reset values; no pulse emitted.

Test Plan:
- Note curr_note=0x004, hold_length=3; keys=0x004 asserted 1 frame before note start and held 5 frames → hit pulse once, score=10, streak=1, best_streak=1.
- Same note, keys released after 2 synced frames of hold → miss pulse, score += 2, streak=0, judge_state=DONE.
- curr_note=0x100, keys=0x101 pressed within window → miss on first synced frame; score unchanged.
- curr_note=0x010, hold_length=2, no key press → miss when note_age reaches 2 → judge_state DONE.
- Rest note (curr_note=0) for 2 frames, no keys → no pulses; a preceding streak of 3 is preserved.
- Repeated identical notes {0x001, len 2} ×2, held continuously → two hit pulses 2 frames apart, score=20.
- Reset with score at 0xFFFA → all outputs 0.
- Separately, preload score near max and hit → saturates at 0xFFFF.
- game_frame forced to 0 during HOLD → no pulse; FSM restarts on the new note.
